fetch_stage: RTL and testbench

// Instruction fetch stage; sits between pc_gen_stage and decode. Issues one imem read per PC

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// mmm_pkg: core-wide widths shared by the pipeline stages.
// fetch_stage: instruction fetch between pc_gen_stage and decode.
//   Issues one imem read per PC offered by pc_gen_stage (fetch_ready_o advances
//   it), tracks in-flight requests in an in-order PC queue, buffers returned
//   {pc, instr} pairs in an in-order instruction queue for decode, and discards
//   stale responses after a flush.
//
// Ports
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   flush_i                kill in-flight work this cycle (exception/mispredict)
//   pc_i                   PC offered by pc_gen_stage
//   fetch_ready_o          request accepted this cycle (combinational)
//   imem_req_valid_o/_ready_i, imem_addr_o    imem request channel
//   imem_resp_valid_i, imem_resp_data_i       imem response (in request order)
//   instr_valid_o/instr_ready_i, instr_o, instr_pc_o   head of queue to decode
// -----------------------------------------------------------------------------
package mmm_pkg;
  parameter int XLEN = 32;
  parameter int ILEN = 32;
endpackage

module fetch_stage
  import mmm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            fetch_ready_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [ILEN-1:0] imem_resp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  // Index widths. The in-flight PC store is rounded up to at least two slots so
  // that MAX_OUTST=1 still has a real index bit; the credit check keeps its
  // occupancy at or below MAX_OUTST regardless.
  localparam int QIW      = $clog2(FIFO_DEPTH);
  localparam int OIW      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OF_SLOTS = 1 << OIW;
  localparam int SW       = ((QIW > OIW) ? QIW : OIW) + 2;

  localparam logic [QIW:0] Q_ONE     = {{QIW{1'b0}}, 1'b1};
  localparam logic [OIW:0] O_ONE     = {{OIW{1'b0}}, 1'b1};
  localparam logic [OIW:0] OUTST_LIM = (OIW + 1)'(MAX_OUTST);
  localparam logic [SW-1:0] DEPTH_LIM = SW'(FIFO_DEPTH);

  // Pointers carry one extra wrap bit; occupancy is their difference.
  logic [QIW:0]    q_wr_ptr;
  logic [QIW:0]    q_rd_ptr;
  logic [QIW:0]    q_cnt;
  logic [OIW:0]    of_wr_ptr;
  logic [OIW:0]    of_rd_ptr;
  logic [OIW:0]    outst_cnt;
  logic [OIW:0]    discard_cnt;
  logic [SW-1:0]   occupancy;

  logic [XLEN-1:0] q_pc_mem    [FIFO_DEPTH];
  logic [ILEN-1:0] q_instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] of_pc_mem   [OF_SLOTS];

  logic credit_ok;
  logic accept;
  logic resp_fire;
  logic drop;
  logic push;
  logic pop;

  assign q_cnt     = q_wr_ptr - q_rd_ptr;
  assign outst_cnt = of_wr_ptr - of_rd_ptr;
  assign occupancy = SW'(q_cnt) + SW'(outst_cnt);

  always_comb begin
    credit_ok        = 1'b0;
    imem_req_valid_o = 1'b0;
    accept           = 1'b0;
    resp_fire        = 1'b0;
    drop             = 1'b0;
    push             = 1'b0;
    instr_valid_o    = 1'b0;
    pop              = 1'b0;

    // Every issued request reserves a queue slot up front, so responses can
    // always be absorbed and the instruction queue never overflows.
    credit_ok        = (outst_cnt < OUTST_LIM) && (occupancy < DEPTH_LIM);
    imem_req_valid_o = rst_n_i & ~flush_i & credit_ok;
    accept           = imem_req_valid_o & imem_req_ready_i;

    // A response with nothing outstanding is ignored rather than corrupting
    // the pointers.
    resp_fire        = imem_resp_valid_i & (outst_cnt != '0);
    drop             = resp_fire & (flush_i | (discard_cnt != '0));
    push             = resp_fire & ~drop;

    instr_valid_o    = (q_cnt != '0) & ~flush_i;
    pop              = instr_valid_o & instr_ready_i;
  end

  assign fetch_ready_o = accept;
  assign imem_addr_o   = pc_i;
  assign instr_o       = q_instr_mem[q_rd_ptr[QIW-1:0]];
  assign instr_pc_o    = q_pc_mem[q_rd_ptr[QIW-1:0]];

  // Storage arrays carry no reset; validity comes from the pointers.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      of_pc_mem[of_wr_ptr[OIW-1:0]] <= pc_i;
    end
    if (push) begin
      q_pc_mem[q_wr_ptr[QIW-1:0]]    <= of_pc_mem[of_rd_ptr[OIW-1:0]];
      q_instr_mem[q_wr_ptr[QIW-1:0]] <= imem_resp_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_wr_ptr    <= '0;
      q_rd_ptr    <= '0;
      of_wr_ptr   <= '0;
      of_rd_ptr   <= '0;
      discard_cnt <= '0;
    end else begin
      if (accept) begin
        of_wr_ptr <= of_wr_ptr + O_ONE;
      end
      if (resp_fire) begin
        of_rd_ptr <= of_rd_ptr + O_ONE;
      end

      // During a flush neither push nor pop can happen, so emptying the queue
      // is just catching the read pointer up with the write pointer.
      if (flush_i) begin
        q_rd_ptr <= q_wr_ptr;
      end else begin
        if (push) begin
          q_wr_ptr <= q_wr_ptr + Q_ONE;
        end
        if (pop) begin
          q_rd_ptr <= q_rd_ptr + Q_ONE;
        end
      end

      // Everything still in flight after this edge is stale. A flush during an
      // ongoing discard recomputes the count from scratch, which is correct
      // because the older stale requests are a subset of those in flight.
      if (flush_i) begin
        discard_cnt <= outst_cnt - {{OIW{1'b0}}, resp_fire};
      end else if (drop && (discard_cnt != '0)) begin
        discard_cnt <= discard_cnt - O_ONE;
      end
    end
  end

`ifndef SYNTHESIS
  resp_without_request: assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
      imem_resp_valid_i |-> (outst_cnt != '0)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_stage: table of per-cycle vectors for in-order fetch,
// decode backpressure and imem stalls, hand sequences for flush corner cases,
// a randomised run against a scoreboard, and a mid-operation reset.
// imem data for address pc is always {16'hABCD, pc[15:0]}.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  typedef struct {
    logic        flush;
    logic [31:0] pc;
    logic        rr;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        e_fr;
    logic        e_rv;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic [31:0] pc_i;
  logic        fetch_ready_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.FIFO_DEPTH(4), .MAX_OUTST(2)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .flush_i           (flush_i),
    .pc_i              (pc_i),
    .fetch_ready_o     (fetch_ready_o),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o)
  );

  function automatic vec_t mk(input logic fl, input logic [31:0] pc, input logic rr,
                              input logic rv, input logic [31:0] rd, input logic ir,
                              input logic efr, input logic erv, input logic eiv,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.flush = fl; v.pc = pc; v.rr = rr; v.rv = rv; v.rdata = rd; v.ir = ir;
    v.e_fr = efr; v.e_rv = erv; v.e_iv = eiv; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  function automatic logic [31:0] imem_data(input logic [31:0] pc);
    return {16'hABCD, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [31:0] pc, input logic rr,
                       input logic rv, input logic [31:0] rd, input logic ir);
    flush_i           = fl;
    pc_i              = pc;
    imem_req_ready_i  = rr;
    imem_resp_valid_i = rv;
    imem_resp_data_i  = rd;
    instr_ready_i     = ir;
  endtask

  // One cycle: drive at edge+1, compare at edge+3, advance to next edge+1.
  task automatic apply(input string tag, input int idx, input vec_t v);
    drive(v.flush, v.pc, v.rr, v.rv, v.rdata, v.ir);
    #2;
    $display("%s[%0d] pc=%h fr=%b rv=%b iv=%b instr=%h ipc=%h", tag, idx, v.pc,
             fetch_ready_o, imem_req_valid_o, instr_valid_o, instr_o, instr_pc_o);
    chk($sformatf("%s[%0d].fetch_ready", tag, idx), 32'(fetch_ready_o), 32'(v.e_fr));
    chk($sformatf("%s[%0d].req_valid", tag, idx), 32'(imem_req_valid_o), 32'(v.e_rv));
    chk($sformatf("%s[%0d].instr_valid", tag, idx), 32'(instr_valid_o), 32'(v.e_iv));
    if (v.e_rv) chk($sformatf("%s[%0d].addr", tag, idx), imem_addr_o, v.pc);
    if (v.e_iv) begin
      chk($sformatf("%s[%0d].instr", tag, idx), instr_o, v.e_instr);
      chk($sformatf("%s[%0d].instr_pc", tag, idx), instr_pc_o, v.e_pc);
    end
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[21];

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_pc[$];

  initial begin
    int          last_due;
    int          due;
    logic [31:0] cur_pc;
    logic        fl, rr, ir, rv;
    logic [31:0] rd;

    // In-order fetch (1-cycle imem), imem stall, decode stall with full credit.
    tbl[0]  = mk(0, 32'h80000000, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0);
    tbl[1]  = mk(0, 32'h80000004, 1, 1, 32'hABCD0000, 1, 1, 1, 0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 32'h80000008, 1, 1, 32'hABCD0004, 1, 1, 1, 1, 32'hABCD0000, 32'h80000000);
    tbl[3]  = mk(0, 32'h8000000C, 1, 1, 32'hABCD0008, 1, 1, 1, 1, 32'hABCD0004, 32'h80000004);
    tbl[4]  = mk(0, 32'h80000010, 0, 1, 32'hABCD000C, 1, 0, 1, 1, 32'hABCD0008, 32'h80000008);
    tbl[5]  = mk(0, 32'h80000010, 0, 0, 32'h0,        1, 0, 1, 1, 32'hABCD000C, 32'h8000000C);
    tbl[6]  = mk(0, 32'h80000010, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0);
    tbl[7]  = mk(0, 32'h80000010, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0);
    tbl[8]  = mk(0, 32'h80000014, 1, 1, 32'hABCD0010, 0, 1, 1, 0, 32'h0,        32'h0);
    tbl[9]  = mk(0, 32'h80000018, 1, 1, 32'hABCD0014, 0, 1, 1, 1, 32'hABCD0010, 32'h80000010);
    tbl[10] = mk(0, 32'h8000001C, 1, 1, 32'hABCD0018, 0, 1, 1, 1, 32'hABCD0010, 32'h80000010);
    tbl[11] = mk(0, 32'h80000020, 1, 1, 32'hABCD001C, 0, 0, 0, 1, 32'hABCD0010, 32'h80000010);
    tbl[12] = mk(0, 32'h80000020, 1, 0, 32'h0,        0, 0, 0, 1, 32'hABCD0010, 32'h80000010);
    tbl[13] = mk(0, 32'h80000020, 1, 0, 32'h0,        0, 0, 0, 1, 32'hABCD0010, 32'h80000010);
    tbl[14] = mk(0, 32'h80000020, 1, 0, 32'h0,        1, 0, 0, 1, 32'hABCD0010, 32'h80000010);
    tbl[15] = mk(0, 32'h80000020, 1, 0, 32'h0,        0, 1, 1, 1, 32'hABCD0014, 32'h80000014);
    tbl[16] = mk(0, 32'h80000024, 0, 1, 32'hABCD0020, 1, 0, 0, 1, 32'hABCD0014, 32'h80000014);
    tbl[17] = mk(0, 32'h80000024, 0, 0, 32'h0,        1, 0, 1, 1, 32'hABCD0018, 32'h80000018);
    tbl[18] = mk(0, 32'h80000024, 0, 0, 32'h0,        1, 0, 1, 1, 32'hABCD001C, 32'h8000001C);
    tbl[19] = mk(0, 32'h80000024, 0, 0, 32'h0,        1, 0, 1, 1, 32'hABCD0020, 32'h80000020);
    tbl[20] = mk(0, 32'h80000024, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0);

    // Reset state
    rst_n_i = 1'b0;
    drive(0, 32'h80000000, 1, 0, 32'h0, 1);
    #3;
    chk("reset.fetch_ready", 32'(fetch_ready_o), 32'd0);
    chk("reset.req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("reset.instr_valid", 32'(instr_valid_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    for (int i = 0; i < 21; i++) apply("tbl", i, tbl[i]);

    // Flush with two outstanding; redirect target is the first delivered.
    apply("flush2", 0, mk(0, 32'h100, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0));
    apply("flush2", 1, mk(0, 32'h104, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0));
    apply("flush2", 2, mk(1, 32'h108, 1, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0));
    apply("flush2", 3, mk(0, 32'h400, 1, 1, 32'hABCD0100, 1, 0, 0, 0, 32'h0,        32'h0));
    apply("flush2", 4, mk(0, 32'h400, 1, 1, 32'hABCD0104, 1, 1, 1, 0, 32'h0,        32'h0));
    apply("flush2", 5, mk(0, 32'h404, 0, 1, 32'hABCD0400, 1, 0, 1, 0, 32'h0,        32'h0));
    apply("flush2", 6, mk(0, 32'h404, 0, 0, 32'h0,        1, 0, 1, 1, 32'hABCD0400, 32'h400));
    apply("flush2", 7, mk(0, 32'h404, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0));

    // Flush coinciding with a response, one more stale behind it.
    apply("flushr", 0, mk(0, 32'h100, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0));
    apply("flushr", 1, mk(0, 32'h104, 1, 1, 32'hABCD0100, 1, 1, 1, 0, 32'h0,        32'h0));
    apply("flushr", 2, mk(0, 32'h108, 1, 0, 32'h0,        1, 1, 1, 1, 32'hABCD0100, 32'h100));
    apply("flushr", 3, mk(1, 32'h10C, 1, 1, 32'hABCD0104, 1, 0, 0, 0, 32'h0,        32'h0));
    apply("flushr", 4, mk(0, 32'h200, 1, 1, 32'hABCD0108, 1, 1, 1, 0, 32'h0,        32'h0));
    apply("flushr", 5, mk(0, 32'h204, 1, 1, 32'hABCD0200, 1, 1, 1, 0, 32'h0,        32'h0));
    apply("flushr", 6, mk(0, 32'h208, 0, 1, 32'hABCD0204, 1, 0, 1, 1, 32'hABCD0200, 32'h200));
    apply("flushr", 7, mk(0, 32'h208, 0, 0, 32'h0,        1, 0, 1, 1, 32'hABCD0204, 32'h204));
    apply("flushr", 8, mk(0, 32'h208, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0));

    // Back-to-back flushes, the second one alongside a stale response.
    apply("flushbb", 0, mk(0, 32'h300, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0));
    apply("flushbb", 1, mk(0, 32'h304, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        32'h0));
    apply("flushbb", 2, mk(1, 32'h308, 1, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0));
    apply("flushbb", 3, mk(1, 32'h500, 1, 1, 32'hABCD0300, 1, 0, 0, 0, 32'h0,        32'h0));
    apply("flushbb", 4, mk(0, 32'h500, 1, 1, 32'hABCD0304, 1, 1, 1, 0, 32'h0,        32'h0));
    apply("flushbb", 5, mk(0, 32'h504, 0, 1, 32'hABCD0500, 1, 0, 1, 0, 32'h0,        32'h0));
    apply("flushbb", 6, mk(0, 32'h504, 0, 0, 32'h0,        1, 0, 1, 1, 32'hABCD0500, 32'h500));
    apply("flushbb", 7, mk(0, 32'h504, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0));

    // Random imem latency, decode stalls and flushes against a scoreboard.
    last_due = 0;
    cur_pc   = 32'h1000;
    for (int c = 0; c < 1400; c++) begin
      bit draining;
      draining = (c >= 900);
      if (draining && pend_addr.size() == 0 && exp_pc.size() == 0) break;
      fl = !draining && ($urandom_range(0, 15) == 0);
      rr = draining ? 1'b0 : ($urandom_range(0, 3) != 0);
      ir = draining ? 1'b1 : ($urandom_range(0, 2) != 0);
      rv = 1'b0;
      rd = 32'h0;
      if (pend_addr.size() > 0 && pend_due[0] <= c) begin
        rv = 1'b1;
        rd = imem_data(pend_addr[0]);
      end
      drive(fl, cur_pc, rr, rv, rd, ir);
      #2;
      if (fl) begin
        chk("rand.flush_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rand.flush_instr_valid", 32'(instr_valid_o), 32'd0);
      end
      if (instr_valid_o && ir) begin
        if (exp_pc.size() == 0) begin
          chk("rand.unexpected_instr_pc", instr_pc_o, 32'hFFFFFFFF);
        end else begin
          $display("rand pop pc=%h instr=%h", instr_pc_o, instr_o);
          chk("rand.instr_pc", instr_pc_o, exp_pc[0]);
          chk("rand.instr", instr_o, imem_data(exp_pc[0]));
          void'(exp_pc.pop_front());
        end
      end
      if (rv) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (fl) exp_pc.delete();
      if (fetch_ready_o) begin
        chk("rand.accept_addr", imem_addr_o, cur_pc);
        due = c + int'($urandom_range(1, 5));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(cur_pc);
        pend_due.push_back(due);
        exp_pc.push_back(cur_pc);
        chk("rand.outstanding_le_2", 32'(pend_addr.size() <= 2), 32'd1);
        chk("rand.inflight_le_4", 32'(exp_pc.size() <= 4), 32'd1);
        cur_pc = cur_pc + 32'd4;
      end
      if (fl) cur_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      @(posedge clk_i);
      #1;
    end
    drive(0, cur_pc, 0, 0, 32'h0, 1);
    #2;
    chk("rand.drain_pending", 32'(pend_addr.size()), 32'd0);
    chk("rand.drain_expected", 32'(exp_pc.size()), 32'd0);
    chk("rand.drain_instr_valid", 32'(instr_valid_o), 32'd0);
    @(posedge clk_i);
    #1;

    // Reset with one queued instruction and one outstanding request.
    apply("rstmid", 0, mk(0, 32'h600, 1, 0, 32'h0,        0, 1, 1, 0, 32'h0, 32'h0));
    apply("rstmid", 1, mk(0, 32'h604, 1, 1, 32'hABCD0600, 0, 1, 1, 0, 32'h0, 32'h0));
    drive(0, 32'h604, 1, 0, 32'h0, 0);
    #2;
    chk("rstmid.pre_instr_valid", 32'(instr_valid_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("rstmid.fetch_ready", 32'(fetch_ready_o), 32'd0);
    chk("rstmid.req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("rstmid.instr_valid", 32'(instr_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    apply("rstmid", 2, mk(0, 32'h700, 1, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h0));
    apply("rstmid", 3, mk(0, 32'h704, 1, 0, 32'h0, 1, 1, 1, 0, 32'h0, 32'h0));
    apply("rstmid", 4, mk(0, 32'h708, 1, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
